// File: rtl/noc_link_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC link channel; a grant is held until the last flit is accepted.
// Define NOC_ARB_OUTREG_EN to register out_* through a 2-entry skid buffer (cuts the out_ready -> in_ready path).
module noc_link_arbiter #(
  parameter int FLIT_WIDTH = 34,
  parameter int INPUTS     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]            in_last,
  input  logic [INPUTS-1:0]            in_valid,
  output logic [INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INPUTS-1:0]            grant
);
  localparam int PW = $clog2(INPUTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_ptr, w_ptr_nxt;
  logic [PW-1:0]         r_idx, w_idx_nxt;
  logic [INPUTS-1:0]     r_grant, w_grant_nxt;
  logic [PW-1:0]         w_pick, w_cand;
  logic                  w_pick_vld;
  logic                  w_locked;
  logic                  w_sel_vld, w_sel_last;
  logic [FLIT_WIDTH-1:0] w_sel_flit;
  logic                  w_up_rdy;
  logic                  w_accept;

  // Scan downward so the candidate closest to ptr+1 overwrites the others.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_cand     = '0;
    for (int k = INPUTS; k >= 1; k--) begin
      w_cand = PW'((int'(r_ptr) + k) % INPUTS);
      if (in_valid[w_cand]) begin
        w_pick     = w_cand;
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_locked   = (r_state == LOCKED);
  assign w_sel_vld  = in_valid[r_idx];
  assign w_sel_last = in_last[r_idx];
  assign w_sel_flit = in_flit[int'(r_idx)*FLIT_WIDTH +: FLIT_WIDTH];
  assign w_accept   = w_locked && w_sel_vld && w_up_rdy;
  assign in_ready   = r_grant & {INPUTS{w_up_rdy}};
  assign grant      = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = LOCKED;
          w_idx_nxt   = w_pick;
          w_grant_nxt = {{(INPUTS-1){1'b0}}, 1'b1} << w_pick;
        end
      end
      LOCKED: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_idx;
          w_grant_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= PW'(INPUTS-1);
      r_idx   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_grant <= w_grant_nxt;
    end
  end

`ifdef NOC_ARB_OUTREG_EN
  logic [FLIT_WIDTH:0] r_buf [2];
  logic                r_wr, r_rd;
  logic [1:0]          r_cnt;
  logic                w_pop;

  // Readiness depends only on occupancy, so upstream never sees out_ready combinationally.
  assign w_up_rdy = (r_cnt != 2'd2);
  assign w_pop    = (r_cnt != 2'd0) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_buf[r_wr] <= {w_sel_last, w_sel_flit};
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_cnt <= r_cnt + {1'b0, w_accept} - {1'b0, w_pop};
    end
  end

  assign out_valid             = (r_cnt != 2'd0);
  assign {out_last, out_flit}  = out_valid ? r_buf[r_rd] : '0;
`else
  assign w_up_rdy  = out_ready;
  assign out_valid = w_locked && w_sel_vld;
  assign out_last  = w_locked && w_sel_last;
  assign out_flit  = w_locked ? w_sel_flit : '0;
`endif

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Bench for noc_link_arbiter (pass-through build): directed vector table, a bounded-wait sequence,
// and randomized traffic against a packet-level round-robin reference model.
module tb_noc_link_arbiter;
  localparam int FW = 34;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*FW-1:0] in_flit = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [FW-1:0]   out_flit;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N-1:0]    grant;

  int checks = 0;
  int errors = 0;

  noc_link_arbiter #(.FLIT_WIDTH(FW), .INPUTS(N)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       ordy;
    logic [7:0] seq;
    logic [3:0] e_gnt;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic       e_ol;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic v(input logic r, input logic [3:0] vl, input logic [3:0] ls, input logic ordy,
                   input logic [7:0] seq, input logic [3:0] eg, input logic [3:0] er,
                   input logic eov, input logic eol);
    vec_t t;
    t.rst = r; t.vld = vl; t.lst = ls; t.ordy = ordy; t.seq = seq;
    t.e_gnt = eg; t.e_rdy = er; t.e_ov = eov; t.e_ol = eol;
    vq.push_back(t);
  endtask

  function automatic logic [FW-1:0] tflit(input int i, input logic [7:0] seq);
    return FW'(i * 256 + int'(seq));
  endfunction

  function automatic int oh2idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic apply(input vec_t t, input int n);
    string tag;
    @(posedge clk);
    #1;
    rst = t.rst; in_valid = t.vld; in_last = t.lst; out_ready = t.ordy;
    for (int i = 0; i < N; i++) in_flit[i*FW +: FW] = tflit(i, t.seq);
    #1;
    tag = $sformatf("v%0d", n);
    chk({tag, "_grant"}, 64'(grant), 64'(t.e_gnt));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(t.e_rdy));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(t.e_ov));
    if (t.e_ov || t.rst) begin
      chk({tag, "_out_last"}, 64'(out_last), 64'(t.e_ol));
      chk({tag, "_out_flit"}, 64'(out_flit),
          t.rst ? 64'd0 : 64'(tflit(oh2idx(t.e_gnt), t.seq)));
    end
  endtask

  // Random traffic state and reference model
  int         src_pkt[N], src_fidx[N], src_len[N];
  bit         src_v[N];
  int         owner, last_served;

  function automatic logic [FW-1:0] rflit(input int i);
    return FW'(i * (1 << 24) + src_pkt[i] * 256 + src_fidx[i]);
  endfunction

  initial begin
    int n;
    // Single source, 3-flit packet on input 1
    v(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0010, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0010, 4'b0000, 1, 1, 4'b0010, 4'b0010, 1, 0);
    v(0, 4'b0010, 4'b0000, 1, 2, 4'b0010, 4'b0010, 1, 0);
    v(0, 4'b0010, 4'b0010, 1, 3, 4'b0010, 4'b0010, 1, 1);
    v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // Contention between inputs 0 and 2 right after reset
    v(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0101, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0101, 4'b0000, 1, 1, 4'b0001, 4'b0001, 1, 0);
    v(0, 4'b0101, 4'b0001, 1, 2, 4'b0001, 4'b0001, 1, 1);
    v(0, 4'b0100, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0100, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1, 0);
    v(0, 4'b0100, 4'b0100, 1, 2, 4'b0100, 4'b0100, 1, 1);
    v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // Fairness: all inputs stream single-flit packets
    v(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < N; g++) begin
        v(0, 4'b1111, 4'b1111, 1, 8'(g), 4'b0000, 4'b0000, 0, 0);
        v(0, 4'b1111, 4'b1111, 1, 8'(g), 4'(1 << g), 4'(1 << g), 1, 1);
      end
    v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // Backpressure mid-packet on input 3; input 1 waits
    v(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b1000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b1000, 4'b0000, 1, 1, 4'b1000, 4'b1000, 1, 0);
    for (int s = 0; s < 5; s++)
      v(0, 4'b1010, 4'b0000, 0, 2, 4'b1000, 4'b0000, 1, 0);
    v(0, 4'b1010, 4'b0000, 1, 2, 4'b1000, 4'b1000, 1, 0);
    v(0, 4'b1010, 4'b1000, 1, 3, 4'b1000, 4'b1000, 1, 1);
    v(0, 4'b0010, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0010, 4'b0010, 1, 1, 4'b0010, 4'b0010, 1, 1);
    v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // Gap: granted input 0 idles for 3 cycles while input 1 requests
    v(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0001, 4'b0000, 1, 1, 4'b0001, 4'b0001, 1, 0);
    for (int s = 0; s < 3; s++)
      v(0, 4'b0010, 4'b0000, 1, 2, 4'b0001, 4'b0001, 0, 0);
    v(0, 4'b0011, 4'b0001, 1, 2, 4'b0001, 4'b0001, 1, 1);
    v(0, 4'b0010, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0010, 4'b0010, 1, 1, 4'b0010, 4'b0010, 1, 1);
    v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // Reset after flit 2 of 4 on input 2; rearbitration restarts at input 0
    v(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b0100, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1, 0);
    v(0, 4'b0100, 4'b0000, 1, 2, 4'b0100, 4'b0100, 1, 0);
    v(1, 4'b0100, 4'b0000, 1, 3, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);
    v(0, 4'b1111, 4'b1111, 1, 1, 4'b0001, 4'b0001, 1, 1);
    v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);

    for (int k = 0; k < vq.size(); k++) apply(vq[k], k);

    // Bounded wait: a lone request on input 3 must be granted after one edge
    @(posedge clk); #1;
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 4'b1000; in_last = 4'b1000;
    in_flit[3*FW +: FW] = FW'(34'h2_dead_beef);
    n = 0;
    while (grant !== 4'b1000 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("arb_latency", 64'(n), 64'd1);
    chk("lone_in_ready", 64'(in_ready), 64'h8);
    chk("lone_out_flit", 64'(out_flit), 64'h2_dead_beef);
    @(posedge clk); #1;
    in_valid = '0; in_last = '0;
    chk("lone_release", 64'(grant), 64'd0);

    // Randomized traffic
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    owner = -1;
    last_served = N - 1;
    for (int i = 0; i < N; i++) begin
      src_pkt[i] = 0; src_fidx[i] = 0; src_len[i] = $urandom_range(1, 4); src_v[i] = 0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [3:0] e_gnt, e_rdy;
      logic       e_ov;
      int         acc;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!src_v[i] && $urandom_range(0, 99) < 45) src_v[i] = 1;
        in_valid[i] = src_v[i];
        in_last[i]  = src_v[i] && (src_fidx[i] == src_len[i] - 1);
        in_flit[i*FW +: FW] = rflit(i);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      e_gnt = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
      e_rdy = (owner >= 0 && out_ready) ? e_gnt : 4'b0000;
      e_ov  = (owner >= 0) && src_v[owner];
      chk($sformatf("rnd%0d_grant", cyc), 64'(grant), 64'(e_gnt));
      chk($sformatf("rnd%0d_in_ready", cyc), 64'(in_ready), 64'(e_rdy));
      chk($sformatf("rnd%0d_out_valid", cyc), 64'(out_valid), 64'(e_ov));
      if (e_ov) begin
        chk($sformatf("rnd%0d_out_flit", cyc), 64'(out_flit), 64'(rflit(owner)));
        chk($sformatf("rnd%0d_out_last", cyc), 64'(out_last),
            64'(src_fidx[owner] == src_len[owner] - 1));
      end
      acc = -1;
      if (owner < 0) begin
        for (int k = N; k >= 1; k--)
          if (src_v[(last_served + k) % N]) owner = (last_served + k) % N;
      end else if (src_v[owner] && out_ready) begin
        acc = owner;
        if (src_fidx[owner] == src_len[owner] - 1) begin
          last_served = owner;
          owner = -1;
        end
      end
      if (acc >= 0) begin
        src_v[acc] = 0;
        if (src_fidx[acc] == src_len[acc] - 1) begin
          src_pkt[acc]++;
          src_fidx[acc] = 0;
          src_len[acc] = $urandom_range(1, 4);
        end else begin
          src_fidx[acc]++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
